regfile_write_sequencer: RTL and testbench
==========================================

Name: regfile_write_sequencer

Overview:
- Owns the single write port of the 15-entry, 64-bit Y-86 register file.
- Accepts one write-back request per instruction and turns it into 0, 1 or 2 single-port register writes over consecutive cycles. popq needs two writes: %rsp and rA.
- Arbitrates a host/debug write port against the write-back stream, with a bounded-wait fairness rule.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 64, register width.
- HOST_MAX_WAIT, 4, cycles a pending host request may be refused before it takes priority over write-back.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  1  write-back request valid.
- wb_ready  out  1  sequencer can accept a write-back request.
- icode  in  4  instruction code of the request.
- ra  in  4  rA field.
- rb  in  4  rB field.
- cond  in  1  condition flag, used by cmovq.
- valE  in  DATA_W  ALU result.
- valM  in  DATA_W  memory read data.
- wb_done  out  1  one-cycle pulse in the final cycle of a write-back request.
- host_req  in  1  host write request; held high until granted.
- host_addr  in  4  host target register.
- host_data  in  DATA_W  host write data.
- host_gnt  out  1  one-cycle pulse when the host request is accepted.
- rf_we  out  1  register-file write enable.
- rf_addr  out  4  register-file write address.
- rf_data  out  DATA_W  register-file write data.

Behaviour:
- Reset, asynchronous: state=IDLE; starve_cnt=0; latched request cleared; rf_we, rf_addr, rf_data, wb_done, host_gnt all 0; wb_ready=0 while rst is high.
- States: IDLE, WR1, WR2, HOST. rf_* and wb_done decode from registered state and latched fields only; there is no combinational path from inputs.
- IDLE: wb_ready=1, except when host priority applies (below).
  - wb_valid&&wb_ready: latch icode/ra/rb/cond/valE/valM; go to WR1.
  - Otherwise, if host_req: host_gnt=1, latch host_addr/host_data, go to HOST.
  - Host priority: starve_cnt==HOST_MAX_WAIT && host_req forces wb_ready=0 and grants the host.
- Write slots (first, second):
  - 2 cmovq: (rb<-valE) only if cond, else none.
  - 3 irmovq: (rb<-valE).
  - 5 mrmovq: (ra<-valM).
  - 6 OPq: (rb<-valE).
  - 8 call, 9 ret, A pushq: (4<-valE).
  - B popq: (4<-valE), then (ra<-valM).
  - All other icodes: none.
- Any slot whose address is 4'hF is suppressed (rf_we=0).
- WR1: drive the first slot (rf_we=0 if none).
  - popq: go to WR2.
  - Otherwise: wb_done=1, go to IDLE.
- WR2: drive the second slot; wb_done=1; go to IDLE.
  - Ordering guarantees that popq %rsp leaves %rsp=valM.
- HOST: rf_we=(host_addr!=F), rf_addr/rf_data from latched host fields; go to IDLE.
- Latency, request accepted at edge T:
  - Single-write or no-write: write and wb_done in cycle T+1; wb_ready high again at T+2.
  - popq: writes in T+1 and T+2; wb_done in T+2.
- At most one rf write per cycle, ever.
- starve_cnt: increments, saturating at HOST_MAX_WAIT, each cycle host_req=1 and host_gnt=0. Clears on host_gnt or when host_req=0.
- Simultaneous wb_valid and host_req in IDLE: write-back wins unless starve_cnt is saturated.
- Reset mid-operation: any pending WR2/HOST write is dropped; no partial second write after reset release.
- wb fields are sampled only at the accept edge; later input changes have no effect.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: I_CMOVQ=2, I_IRMOVQ=3, I_MRMOVQ=5, I_OPQ=6, I_CALL=8, I_RET=9, I_PUSHQ=A, I_POPQ=B.
  - Register constants: R_RSP=4, R_NONE=F.
  - FSM state enum.
- Sub-module wb_dest_decode: purely combinational. Maps icode/cond/ra/rb to two slots, each {valid, addr, sel_valM}, plus a two_writes flag.

Test Plan:
- irmovq, rb=3, valE=0x1234, accepted at T -> rf_we=1, rf_addr=3, rf_data=0x1234, wb_done=1 at T+1; wb_ready=1 at T+2.
- popq, ra=4, valE=0x100, valM=0xBEEF -> T+1 writes (4,0x100); T+2 writes (4,0xBEEF) with wb_done=1.
- cmovq, cond=0, rb=2 -> T+1 rf_we=0, wb_done=1. Repeat with cond=1, valE=7 -> write (2,7).
- wb_valid and host_req(addr=5, data=0xAA) held high continuously -> host refused exactly HOST_MAX_WAIT=4 cycles, then host_gnt=1, followed by write (5,0xAA); write-back resumes afterwards.
- mrmovq with ra=F, and host write with addr=F -> no rf_we assertion; wb_done/host_gnt still pulse.
- Assert rst during WR1 of a popq -> all outputs 0 immediately; after release, no WR2 write; state=IDLE, wb_ready=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y-86 constants for the register-file write path: instruction codes,
// special register numbers, sequencer state encodings and the write-slot record.
package y86_pkg;

    localparam logic [3:0] I_CMOVQ  = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WR1  = 2'd1;
    localparam state_t ST_WR2  = 2'd2;
    localparam state_t ST_HOST = 2'd3;

    // valid already accounts for the "no register" address being suppressed
    typedef struct packed {
        logic       valid;
        logic [3:0] addr;
        logic       sel_valm;
    } wr_slot_t;

endpackage

// File: rtl/wb_dest_decode.sv
// Combinational map from a write-back request to its first and second
// register-file write slots.
module wb_dest_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ra,
    input  logic [3:0] rb,
    input  logic       cond,
    output wr_slot_t   slot0,
    output wr_slot_t   slot1,
    output logic       two_writes
);

    always_comb begin
        slot0      = '0;
        slot1      = '0;
        two_writes = 1'b0;
        case (icode)
            I_CMOVQ: begin
                slot0.valid = cond;
                slot0.addr  = rb;
            end
            I_IRMOVQ, I_OPQ: begin
                slot0.valid = 1'b1;
                slot0.addr  = rb;
            end
            I_MRMOVQ: begin
                slot0.valid    = 1'b1;
                slot0.addr     = ra;
                slot0.sel_valm = 1'b1;
            end
            I_CALL, I_RET, I_PUSHQ: begin
                slot0.valid = 1'b1;
                slot0.addr  = R_RSP;
            end
            // %rsp first, then rA, so "popq %rsp" ends with the loaded value
            I_POPQ: begin
                slot0.valid    = 1'b1;
                slot0.addr     = R_RSP;
                slot1.valid    = 1'b1;
                slot1.addr     = ra;
                slot1.sel_valm = 1'b1;
                two_writes     = 1'b1;
            end
            default: begin
                slot0 = '0;
            end
        endcase
        if (slot0.addr == R_NONE) slot0.valid = 1'b0;
        if (slot1.addr == R_NONE) slot1.valid = 1'b0;
    end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Owns the single register-file write port: sequences write-back requests into
// 0-2 writes and arbitrates a host write port with a bounded-wait rule.
module regfile_write_sequencer
    import y86_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ra,
    input  logic [3:0]        rb,
    input  logic              cond,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic              wb_done,
    input  logic              host_req,
    input  logic [3:0]        host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_gnt,
    output logic              rf_we,
    output logic [3:0]        rf_addr,
    output logic [DATA_W-1:0] rf_data
);

    localparam int CNT_W = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(HOST_MAX_WAIT);

    state_t            state;
    logic [CNT_W-1:0]  starve_cnt;
    logic [3:0]        icode_q;
    logic [3:0]        ra_q;
    logic [3:0]        rb_q;
    logic              cond_q;
    logic [DATA_W-1:0] vale_q;
    logic [DATA_W-1:0] valm_q;
    logic [3:0]        host_addr_q;
    logic [DATA_W-1:0] host_data_q;

    logic     host_prio;
    logic     wb_accept;
    wr_slot_t slot0;
    wr_slot_t slot1;
    logic     two_writes;

    wb_dest_decode u_decode (
        .icode      (icode_q),
        .ra         (ra_q),
        .rb         (rb_q),
        .cond       (cond_q),
        .slot0      (slot0),
        .slot1      (slot1),
        .two_writes (two_writes)
    );

    // A starved host blocks write-back for one IDLE cycle and is granted instead
    always_comb begin
        host_prio = host_req && (starve_cnt == MAX_CNT);
        wb_ready  = !rst && (state == ST_IDLE) && !host_prio;
        wb_accept = wb_valid && wb_ready;
        host_gnt  = !rst && (state == ST_IDLE) && host_req && !wb_accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            starve_cnt  <= '0;
            icode_q     <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            cond_q      <= 1'b0;
            vale_q      <= '0;
            valm_q      <= '0;
            host_addr_q <= '0;
            host_data_q <= '0;
        end else begin
            if (!host_req || host_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != MAX_CNT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (wb_accept) begin
                        icode_q <= icode;
                        ra_q    <= ra;
                        rb_q    <= rb;
                        cond_q  <= cond;
                        vale_q  <= valE;
                        valm_q  <= valM;
                        state   <= ST_WR1;
                    end else if (host_gnt) begin
                        host_addr_q <= host_addr;
                        host_data_q <= host_data;
                        state       <= ST_HOST;
                    end
                end
                ST_WR1:  state <= two_writes ? ST_WR2 : ST_IDLE;
                ST_WR2:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write port driven purely from registered state and latched fields
    always_comb begin
        rf_we   = 1'b0;
        rf_addr = '0;
        rf_data = '0;
        wb_done = 1'b0;
        case (state)
            ST_WR1: begin
                wb_done = !two_writes;
                if (slot0.valid) begin
                    rf_we   = 1'b1;
                    rf_addr = slot0.addr;
                    rf_data = slot0.sel_valm ? valm_q : vale_q;
                end
            end
            ST_WR2: begin
                wb_done = 1'b1;
                if (slot1.valid) begin
                    rf_we   = 1'b1;
                    rf_addr = slot1.addr;
                    rf_data = slot1.sel_valm ? valm_q : vale_q;
                end
            end
            ST_HOST: begin
                if (host_addr_q != R_NONE) begin
                    rf_we   = 1'b1;
                    rf_addr = host_addr_q;
                    rf_data = host_data_q;
                end
            end
            default: begin
                rf_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for regfile_write_sequencer: sequencing, host fairness,
// suppressed register F writes and mid-operation reset.
module tb_regfile_write_sequencer;

    localparam int DATA_W = 64;

    logic              clk;
    logic              rst;
    logic              wb_valid;
    logic              wb_ready;
    logic [3:0]        icode;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic              cond;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic              wb_done;
    logic              host_req;
    logic [3:0]        host_addr;
    logic [DATA_W-1:0] host_data;
    logic              host_gnt;
    logic              rf_we;
    logic [3:0]        rf_addr;
    logic [DATA_W-1:0] rf_data;

    int checks;
    int errors;

    regfile_write_sequencer #(.DATA_W(DATA_W), .HOST_MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .icode     (icode),
        .ra        (ra),
        .rb        (rb),
        .cond      (cond),
        .valE      (valE),
        .valM      (valM),
        .wb_done   (wb_done),
        .host_req  (host_req),
        .host_addr (host_addr),
        .host_data (host_data),
        .host_gnt  (host_gnt),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_valid = 1'b0; icode = 4'h0; ra = 4'hF; rb = 4'hF; cond = 1'b0;
        valE = '0; valM = '0; host_req = 1'b0; host_addr = 4'h0; host_data = '0;
        #2;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_we got %b want 0", rf_we); end
        checks++; if (rf_addr !== 4'h0) begin errors++; $display("[TB] FAIL reset_rf_addr got %h want 0", rf_addr); end
        checks++; if (rf_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_rf_data got %h want 0", rf_data); end
        checks++; if (wb_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_done got %b want 0", wb_done); end
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_ready got %b want 0", wb_ready); end
        host_req = 1'b1; #1;
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_host_gnt got %b want 0", host_gnt); end
        host_req = 1'b0;
        step(); step();
        rst = 1'b0; #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_wb_ready got %b want 1", wb_ready); end
    endtask

    task automatic test_irmovq();
        wb_valid = 1'b1; icode = 4'h3; ra = 4'hF; rb = 4'h3; valE = 64'h1234; valM = 64'h9999;
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL irmovq_ready got %b want 1", wb_ready); end
        step();
        wb_valid = 1'b0; rb = 4'h7; valE = 64'hDEAD; #1;
        checks++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 4'h3, 64'h1234})
            begin errors++; $display("[TB] FAIL irmovq_write got we=%b a=%h d=%h want we=1 a=3 d=1234", rf_we, rf_addr, rf_data); end
        checks++; if (wb_done !== 1'b1) begin errors++; $display("[TB] FAIL irmovq_done got %b want 1", wb_done); end
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("[TB] FAIL irmovq_busy got %b want 0", wb_ready); end
        step();
        checks++; if ({wb_ready, rf_we, wb_done} !== 3'b100)
            begin errors++; $display("[TB] FAIL irmovq_idle got ready/we/done=%b want 100", {wb_ready, rf_we, wb_done}); end
    endtask

    task automatic test_popq();
        wb_valid = 1'b1; icode = 4'hB; ra = 4'h4; rb = 4'hF; valE = 64'h100; valM = 64'hBEEF;
        step();
        wb_valid = 1'b0; valM = 64'h0; valE = 64'h0; #1;
        checks++; if ({rf_we, rf_addr, rf_data, wb_done} !== {1'b1, 4'h4, 64'h100, 1'b0})
            begin errors++; $display("[TB] FAIL popq_first got we=%b a=%h d=%h done=%b want 1/4/100/0", rf_we, rf_addr, rf_data, wb_done); end
        step();
        checks++; if ({rf_we, rf_addr, rf_data, wb_done} !== {1'b1, 4'h4, 64'hBEEF, 1'b1})
            begin errors++; $display("[TB] FAIL popq_second got we=%b a=%h d=%h done=%b want 1/4/beef/1", rf_we, rf_addr, rf_data, wb_done); end
        step();
        checks++; if ({wb_ready, rf_we, wb_done} !== 3'b100)
            begin errors++; $display("[TB] FAIL popq_idle got ready/we/done=%b want 100", {wb_ready, rf_we, wb_done}); end
    endtask

    task automatic test_cmovq();
        wb_valid = 1'b1; icode = 4'h2; ra = 4'h1; rb = 4'h2; cond = 1'b0; valE = 64'h7;
        step();
        wb_valid = 1'b0; #1;
        checks++; if ({rf_we, wb_done} !== 2'b01)
            begin errors++; $display("[TB] FAIL cmovq_nocond got we/done=%b want 01", {rf_we, wb_done}); end
        step();
        wb_valid = 1'b1; cond = 1'b1;
        step();
        wb_valid = 1'b0; cond = 1'b0; #1;
        checks++; if ({rf_we, rf_addr, rf_data, wb_done} !== {1'b1, 4'h2, 64'h7, 1'b1})
            begin errors++; $display("[TB] FAIL cmovq_cond got we=%b a=%h d=%h done=%b want 1/2/7/1", rf_we, rf_addr, rf_data, wb_done); end
        step();
    endtask

    task automatic test_host_priority();
        int refused;
        bit granted;
        refused = 0; granted = 0;
        wb_valid = 1'b1; icode = 4'h3; rb = 4'h1; valE = 64'h55;
        host_req = 1'b1; host_addr = 4'h5; host_data = 64'hAA;
        #1;
        for (int i = 0; i < 20 && !granted; i++) begin
            if (host_gnt === 1'b1) granted = 1;
            else begin refused++; step(); end
        end
        checks++; if (!granted) begin errors++; $display("[TB] FAIL host_gnt_timeout got none want grant"); end
        checks++; if (refused !== 4) begin errors++; $display("[TB] FAIL host_refused got %0d want 4", refused); end
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("[TB] FAIL host_prio_ready got %b want 0", wb_ready); end
        step();
        host_req = 1'b0; host_data = 64'h0; #1;
        checks++; if ({rf_we, rf_addr, rf_data, host_gnt} !== {1'b1, 4'h5, 64'hAA, 1'b0})
            begin errors++; $display("[TB] FAIL host_write got we=%b a=%h d=%h gnt=%b want 1/5/aa/0", rf_we, rf_addr, rf_data, host_gnt); end
        step();
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL wb_resume_ready got %b want 1", wb_ready); end
        step();
        wb_valid = 1'b0; #1;
        checks++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 4'h1, 64'h55})
            begin errors++; $display("[TB] FAIL wb_resume_write got we=%b a=%h d=%h want 1/1/55", rf_we, rf_addr, rf_data); end
        step();
    endtask

    task automatic test_reg_none();
        wb_valid = 1'b1; icode = 4'h5; ra = 4'hF; rb = 4'h0; valM = 64'h77;
        step();
        wb_valid = 1'b0; #1;
        checks++; if ({rf_we, wb_done} !== 2'b01)
            begin errors++; $display("[TB] FAIL mrmovq_none got we/done=%b want 01", {rf_we, wb_done}); end
        step();
        host_req = 1'b1; host_addr = 4'hF; host_data = 64'h33; #1;
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("[TB] FAIL host_none_gnt got %b want 1", host_gnt); end
        step();
        host_req = 1'b0; #1;
        checks++; if ({rf_we, wb_ready} !== 2'b00)
            begin errors++; $display("[TB] FAIL host_none_write got we/ready=%b want 00", {rf_we, wb_ready}); end
        step();
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("[TB] FAIL host_none_idle got %b want 1", wb_ready); end
    endtask

    task automatic test_reset_mid();
        wb_valid = 1'b1; icode = 4'hB; ra = 4'h6; valE = 64'h200; valM = 64'h300;
        step();
        wb_valid = 1'b0; #1;
        checks++; if ({rf_we, rf_addr} !== {1'b1, 4'h4})
            begin errors++; $display("[TB] FAIL mid_wr1 got we=%b a=%h want 1/4", rf_we, rf_addr); end
        rst = 1'b1; #1;
        checks++; if ({rf_we, rf_addr, rf_data, wb_done, wb_ready, host_gnt} !== '0)
            begin errors++; $display("[TB] FAIL mid_reset_outputs got we=%b a=%h d=%h done=%b ready=%b gnt=%b want all 0",
                                     rf_we, rf_addr, rf_data, wb_done, wb_ready, host_gnt); end
        step();
        rst = 1'b0; #1;
        checks++; if ({rf_we, wb_done, wb_ready} !== 3'b001)
            begin errors++; $display("[TB] FAIL mid_release got we/done/ready=%b want 001", {rf_we, wb_done, wb_ready}); end
        step();
        checks++; if ({rf_we, wb_done, wb_ready} !== 3'b001)
            begin errors++; $display("[TB] FAIL mid_no_wr2 got we/done/ready=%b want 001", {rf_we, wb_done, wb_ready}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_irmovq();
        test_popq();
        test_cmovq();
        test_host_priority();
        test_reg_none();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
